// File: rtl/galaga_dl_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : galaga_dl_sequencer_if
//  Description : Loader bus between the HPS ioctl stream and the galaga
//                core's dn_* download port.
//                  ioctl_download  HPS streaming flag
//                  ioctl_wr        one-cycle byte strobe
//                  ioctl_addr[25]  byte address
//                  ioctl_dout[8]   byte data
//                  dn_addr[17]     retimed write address to the core
//                  dn_data[8]      retimed write data to the core
//                  dn_wr           one-cycle write strobe to the core
//                  dn_region[2]    ROM region of dn_addr
//                Modport master drives the ioctl side (HPS), modport slave
//                is the sequencer (consumes ioctl, drives dn_*).
//  Revision    : 1.0  initial release
// ============================================================================
interface galaga_dl_sequencer_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [1:0]  dn_region;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  dn_addr, dn_data, dn_wr, dn_region
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output dn_addr, dn_data, dn_wr, dn_region
  );
endinterface
`default_nettype wire

// File: rtl/galaga_dl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : galaga_dl_sequencer
//  Description : Sequences the HPS ROM download into the galaga dn_* loader
//                port and owns the core reset. Each accepted ioctl write is
//                retimed by one clock and tagged with its ROM region; the core
//                is released only after a complete, in-range image plus a
//                settle delay. A user reset while running re-enters the
//                settle delay.
//  Ports       : clk_sys     system clock
//                reset_n     synchronous active-low reset
//                bus         loader bus (slave modport)
//                user_reset  OSD / button reset, level
//                core_reset  active-high reset to the galaga core
//                dl_done     complete, good image loaded
//                dl_error    last download short or out of range
//                dl_sum      (checksum build only) sum of accepted bytes
//  Options     : GALAGA_DL_CHECKSUM_EN adds dl_sum and parameter EXP_SUM; a
//                nonzero EXP_SUM that mismatches at download end is an error.
//  Revision    : 1.0  initial release
// ============================================================================
module galaga_dl_sequencer #(
  parameter int R1_BASE       = 16384,
  parameter int R2_BASE       = 20480,
  parameter int R3_BASE       = 24576,
  parameter int ROM_SIZE      = 40960,
  parameter int SETTLE_CYCLES = 16
`ifdef GALAGA_DL_CHECKSUM_EN
  ,
  parameter logic [15:0] EXP_SUM = 16'h0000
`endif
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  galaga_dl_sequencer_if.slave bus,
  input  logic                 user_reset,
  output logic                 core_reset,
  output logic                 dl_done,
  output logic                 dl_error
`ifdef GALAGA_DL_CHECKSUM_EN
  ,
  output logic [15:0]          dl_sum
`endif
);

  localparam int          SETTLE_W  = $clog2(SETTLE_CYCLES + 1);
  localparam logic [24:0] ROM_END_A = 25'(ROM_SIZE);
  localparam logic [24:0] R1_A      = 25'(R1_BASE);
  localparam logic [24:0] R2_A      = 25'(R2_BASE);
  localparam logic [24:0] R3_A      = 25'(R3_BASE);
  localparam logic [17:0] CNT_FULL  = 18'(ROM_SIZE);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t              state_q;
  logic                dl_q;
  logic                user_q;
  logic                core_reset_q;
  logic                dn_wr_q;
  logic [16:0]         dn_addr_q;
  logic [7:0]          dn_data_q;
  logic [1:0]          dn_region_q;
  logic                dl_done_q;
  logic                dl_error_q;
  logic [17:0]         byte_cnt_q;
  logic                ovf_q;
  logic [SETTLE_W-1:0] settle_q;

  logic       dl_rise;
  logic       wr_live;
  logic       accept;
  logic       reject;
  logic       image_bad;
  logic [1:0] region;

  // A strobe counts only while the HPS is streaming and we are loading; the
  // rise cycle itself already belongs to the new download.
  assign dl_rise = bus.ioctl_download & ~dl_q;
  assign wr_live = bus.ioctl_download & bus.ioctl_wr & ((state_q == S_LOAD) | dl_rise);
  // Full 25-bit compare so any set bit in 24:17 is out of range.
  assign accept  = wr_live & (bus.ioctl_addr <  ROM_END_A);
  assign reject  = wr_live & (bus.ioctl_addr >= ROM_END_A);

  always_comb begin
    region = 2'd3;
    if (bus.ioctl_addr < R1_A)      region = 2'd0;
    else if (bus.ioctl_addr < R2_A) region = 2'd1;
    else if (bus.ioctl_addr < R3_A) region = 2'd2;
  end

`ifdef GALAGA_DL_CHECKSUM_EN
  logic [15:0] sum_q;
  assign image_bad = ovf_q | (byte_cnt_q != CNT_FULL) |
                     ((EXP_SUM != 16'h0000) & (sum_q != EXP_SUM));
  assign dl_sum    = sum_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      sum_q <= 16'h0000;
    end else if (dl_rise) begin
      sum_q <= accept ? {8'h00, bus.ioctl_dout} : 16'h0000;
    end else if (accept) begin
      sum_q <= sum_q + {8'h00, bus.ioctl_dout};
    end
  end
`else
  assign image_bad = ovf_q | (byte_cnt_q != CNT_FULL);
`endif

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      dl_q         <= 1'b0;
      user_q       <= 1'b0;
      core_reset_q <= 1'b1;
      dn_wr_q      <= 1'b0;
      dn_addr_q    <= 17'd0;
      dn_data_q    <= 8'd0;
      dn_region_q  <= 2'd0;
      dl_done_q    <= 1'b0;
      dl_error_q   <= 1'b0;
      byte_cnt_q   <= 18'd0;
      ovf_q        <= 1'b0;
      settle_q     <= '0;
    end else begin
      dl_q    <= bus.ioctl_download;
      user_q  <= user_reset;
      dn_wr_q <= accept;
      if (accept) begin
        dn_addr_q   <= bus.ioctl_addr[16:0];
        dn_data_q   <= bus.ioctl_dout;
        dn_region_q <= region;
      end

      if (dl_rise) begin
        // A new download wins over everything, including user_reset.
        state_q      <= S_LOAD;
        core_reset_q <= 1'b1;
        dl_done_q    <= 1'b0;
        dl_error_q   <= 1'b0;
        byte_cnt_q   <= accept ? 18'd1 : 18'd0;
        ovf_q        <= reject;
      end else begin
        case (state_q)
          S_LOAD: begin
            if (accept && (byte_cnt_q != '1)) byte_cnt_q <= byte_cnt_q + 18'd1;
            if (reject) ovf_q <= 1'b1;
            if (!bus.ioctl_download) begin
              if (image_bad) begin
                state_q    <= S_ERROR;
                dl_error_q <= 1'b1;
              end else begin
                state_q  <= S_SETTLE;
                settle_q <= SETTLE_LOAD;
              end
            end
          end
          S_SETTLE: begin
            // Reloading through the first cycle user_reset reads low makes
            // the release land SETTLE_CYCLES+1 clocks after the drop, same
            // as after a download fall.
            if (user_reset || user_q) begin
              settle_q <= SETTLE_LOAD;
            end else if (settle_q == '0) begin
              state_q      <= S_RUN;
              core_reset_q <= 1'b0;
              dl_done_q    <= 1'b1;
            end else begin
              settle_q <= settle_q - 1'b1;
            end
          end
          S_RUN: begin
            if (user_reset) begin
              state_q      <= S_SETTLE;
              core_reset_q <= 1'b1;
              settle_q     <= SETTLE_LOAD;
            end
          end
          S_IDLE, S_ERROR: begin
            core_reset_q <= 1'b1;
          end
          default: begin
            state_q      <= S_IDLE;
            core_reset_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.dn_wr     = dn_wr_q;
  assign bus.dn_addr   = dn_addr_q;
  assign bus.dn_data   = dn_data_q;
  assign bus.dn_region = dn_region_q;
  assign core_reset    = core_reset_q;
  assign dl_done       = dl_done_q;
  assign dl_error      = dl_error_q;

endmodule
`default_nettype wire

// File: tb/tb_galaga_dl_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_galaga_dl_sequencer
//  Description : Self-checking bench for galaga_dl_sequencer. The image map
//                is scaled down (regions at 64/80/96, image 160 bytes) so
//                several complete downloads fit in a short run; settle delay
//                stays 16. A timestamp-based model predicts every output and
//                is compared each cycle, with literal checks at the region
//                boundaries, release delays and error/done flags.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_galaga_dl_sequencer;

  localparam int P_R1     = 64;
  localparam int P_R2     = 80;
  localparam int P_R3     = 96;
  localparam int P_ROM    = 160;
  localparam int P_SETTLE = 16;

  logic clk_sys    = 1'b0;
  logic reset_n    = 1'b0;
  logic user_reset = 1'b0;
  logic core_reset;
  logic dl_done;
  logic dl_error;
`ifdef GALAGA_DL_CHECKSUM_EN
  logic [15:0] dl_sum;
`endif

  galaga_dl_sequencer_if bus();

  galaga_dl_sequencer #(
    .R1_BASE       (P_R1),
    .R2_BASE       (P_R2),
    .R3_BASE       (P_R3),
    .ROM_SIZE      (P_ROM),
    .SETTLE_CYCLES (P_SETTLE)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .bus        (bus),
    .user_reset (user_reset),
    .core_reset (core_reset),
    .dl_done    (dl_done),
    .dl_error   (dl_error)
`ifdef GALAGA_DL_CHECKSUM_EN
    ,
    .dl_sum     (dl_sum)
`endif
  );

  initial forever #5 clk_sys = ~clk_sys;

  int total    = 0;
  int bad      = 0;
  int edge_cnt = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] region_of(input logic [24:0] a);
    if (a < 25'(P_R1)) return 2'd0;
    if (a < 25'(P_R2)) return 2'd1;
    if (a < 25'(P_R3)) return 2'd2;
    return 2'd3;
  endfunction

  // ---------------- behavioural model ----------------
  bit          m_prev_dl, m_in_load, m_ovf, m_good, m_rise;
  int          m_cnt;
  int          release_at;
  bit          e_wr, e_core_reset, e_done, e_err;
  logic [16:0] e_addr;
  logic [7:0]  e_data;
  logic [1:0]  e_region;

  initial begin
    e_core_reset = 1'b1;
    release_at   = -1;
    forever begin
      @(posedge clk_sys);
      edge_cnt++;
      if (!reset_n) begin
        m_prev_dl = 0; m_in_load = 0; m_ovf = 0; m_good = 0; m_cnt = 0;
        release_at = -1;
        e_wr = 0; e_addr = '0; e_data = '0; e_region = '0;
        e_core_reset = 1; e_done = 0; e_err = 0;
      end else begin
        m_rise    = bus.ioctl_download && !m_prev_dl;
        m_prev_dl = bus.ioctl_download;
        e_wr      = 0;
        if (m_rise) begin
          m_in_load = 1; m_cnt = 0; m_ovf = 0; m_good = 0; release_at = -1;
          e_core_reset = 1; e_done = 0; e_err = 0;
        end
        if (m_in_load) begin
          if (!bus.ioctl_download) begin
            m_in_load = 0;
            if (m_ovf || m_cnt != P_ROM) e_err = 1;
            else begin
              m_good     = 1;
              release_at = edge_cnt + P_SETTLE + 1;
            end
          end else if (bus.ioctl_wr) begin
            if (bus.ioctl_addr < 25'(P_ROM)) begin
              e_wr     = 1;
              e_addr   = bus.ioctl_addr[16:0];
              e_data   = bus.ioctl_dout;
              e_region = region_of(bus.ioctl_addr);
              m_cnt++;
            end else begin
              m_ovf = 1;
            end
          end
        end
        // Release happens SETTLE+1 edges after the first edge user_reset is low.
        if (m_good && user_reset) begin
          e_core_reset = 1;
          release_at   = edge_cnt + P_SETTLE + 2;
        end
        if (release_at == edge_cnt) begin
          e_core_reset = 0;
          e_done       = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk_sys);
    if (chk_on) begin
      chk("dn_wr",      32'(bus.dn_wr),     32'(e_wr));
      chk("dn_addr",    32'(bus.dn_addr),   32'(e_addr));
      chk("dn_data",    32'(bus.dn_data),   32'(e_data));
      chk("dn_region",  32'(bus.dn_region), 32'(e_region));
      chk("core_reset", 32'(core_reset),    32'(e_core_reset));
      chk("dl_done",    32'(dl_done),       32'(e_done));
      chk("dl_error",   32'(dl_error),      32'(e_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_seq(input int n, input int gap, input bit pin);
    int exp_r;
    bus.ioctl_download = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(i);
      bus.ioctl_dout = 8'(i);
      @(negedge clk_sys);
      bus.ioctl_wr = 1'b0;
      if (pin && (i == P_R1 - 1 || i == P_R1 || i == P_R2 || i == P_R3)) begin
        exp_r = (i == P_R1 - 1) ? 0 : (i == P_R1) ? 1 : (i == P_R2) ? 2 : 3;
        chk($sformatf("lit_wr_%0d", i),     32'(bus.dn_wr),     32'd1);
        chk($sformatf("lit_addr_%0d", i),   32'(bus.dn_addr),   32'(i));
        chk($sformatf("lit_data_%0d", i),   32'(bus.dn_data),   32'(i));
        chk($sformatf("lit_region_%0d", i), 32'(bus.dn_region), 32'(exp_r));
      end
      repeat (gap - 1) @(negedge clk_sys);
    end
  endtask

  // Called at the negedge where the triggering input changed; counts edges
  // from the first edge that sees the change until core_reset is low.
  task automatic measure_release(input string nm);
    int t0;
    bit seen;
    seen = 1'b0;
    @(negedge clk_sys);
    t0 = edge_cnt;
    for (int k = 0; k < 100; k++) begin
      if (core_reset == 1'b0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_sys);
    end
    chk(nm, seen ? 32'(edge_cnt - t0) : 32'hFFFF_FFFF, 32'd17);
  endtask

  task automatic probe_wr(input string nm, input logic [24:0] a);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = 8'h5A;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
    chk(nm, 32'(bus.dn_wr), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    reset_n            = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk_on = 1'b1;
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_dn_wr",      32'(bus.dn_wr),  32'd0);
    chk("rst_dl_done",    32'(dl_done),    32'd0);
    chk("rst_dl_error",   32'(dl_error),   32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("idle_core_reset", 32'(core_reset), 32'd1);

    // Full good load, one strobe every 3 clocks
    load_seq(P_ROM, 3, 1'b1);
    bus.ioctl_download = 1'b0;
    measure_release("release_after_load");
    chk("done_after_load",  32'(dl_done),  32'd1);
    chk("error_after_load", 32'(dl_error), 32'd0);

    // Short load -> error, held for 1000 clocks, then recovery
    load_seq(P_ROM - 4, 1, 1'b0);
    bus.ioctl_download = 1'b0;
    repeat (1000) @(negedge clk_sys);
    chk("short_core_reset", 32'(core_reset), 32'd1);
    chk("short_dl_error",   32'(dl_error),   32'd1);
    chk("short_dl_done",    32'(dl_done),    32'd0);
    load_seq(P_ROM, 1, 1'b0);
    bus.ioctl_download = 1'b0;
    measure_release("release_after_recovery");
    chk("done_after_recovery", 32'(dl_done), 32'd1);

    // Full load plus out-of-range writes
    load_seq(P_ROM, 1, 1'b0);
    probe_wr("oor_at_rom_size", 25'(P_ROM));
    probe_wr("oor_bit24",       25'h100_0005);
    bus.ioctl_download = 1'b0;
    repeat (5) @(negedge clk_sys);
    chk("oor_dl_error",   32'(dl_error),   32'd1);
    chk("oor_core_reset", 32'(core_reset), 32'd1);

    // Good load, then user reset while running
    load_seq(P_ROM, 1, 1'b0);
    bus.ioctl_download = 1'b0;
    measure_release("release_before_user");
    user_reset = 1'b1;
    @(negedge clk_sys);
    chk("user_core_reset_next", 32'(core_reset), 32'd1);
    repeat (4) @(negedge clk_sys);
    user_reset = 1'b0;
    measure_release("release_after_user");
    chk("done_after_user", 32'(dl_done), 32'd1);
    probe_wr("stray_wr_no_download", 25'd7);

    // Mid-load abort by reset_n, with a write in flight
    load_seq(100, 1, 1'b0);
    bus.ioctl_wr       = 1'b1;
    bus.ioctl_addr     = 25'd100;
    bus.ioctl_dout     = 8'd100;
    bus.ioctl_download = 1'b0;
    reset_n            = 1'b0;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
    chk("abort_dn_wr",      32'(bus.dn_wr),  32'd0);
    chk("abort_core_reset", 32'(core_reset), 32'd1);
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    chk("abort_dl_done", 32'(dl_done), 32'd0);
    load_seq(P_ROM, 2, 1'b0);
    bus.ioctl_download = 1'b0;
    measure_release("release_after_abort");
    chk("done_after_abort",  32'(dl_done),  32'd1);
    chk("error_after_abort", 32'(dl_error), 32'd0);

    repeat (3) @(negedge clk_sys);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
